rsdec_syndrome_calc: RTL and testbench
======================================

// Module: rsdec_syndrome_calc
// PURPOSE
//  Syndrome stage of the RS(255,223) decoder over GF(2^8), x^8+x^7+x^2+x+1 (0x187), alpha = 0x02.
//  Consumes one received symbol per cycle, highest-degree coefficient first.
//  Computes S_i = r(alpha^(FIRST_ROOT+i)) for i = 0..31 by Horner accumulation.
//  Presents the 32 syndromes, double-buffered, to the Berlekamp-Massey stage directly downstream.
// PARAMETERS
//  N_SYM       255  codeword length in symbols; also the required in_last position
//  FIRST_ROOT  0    exponent of the first generator root; syndrome i uses alpha^(FIRST_ROOT+i)
// PORTS
//  clk            input   1  single clock, rising edge
//  rst_n          input   1  asynchronous, active-low reset
//  in_valid       input   1  in_data is valid this cycle
//  in_ready       output  1  block accepts a symbol this cycle (transfer = in_valid & in_ready)
//  in_data        input   8  received symbol
//  in_last        input   1  marks the final symbol of the codeword
//  out_valid      output  1  syndrome0..31 hold a complete frame
//  out_ack        input   1  downstream has consumed the held syndromes
//  syndrome0..31  output  8  each: held syndrome S_i, stable while out_valid
//  syn_nonzero    output  1  OR of all held syndromes (frame has errors); valid with out_valid
//  len_err        output  1  one-cycle pulse: framing violation detected on the accepted frame
// BEHAVIOUR
//  Reset (rst_n low, any time, including mid-frame):
//   - accumulators, hold registers and symbol counter clear to 0.
//   - out_valid=0, syn_nonzero=0, len_err=0, in_ready=1 one cycle after rst_n rises.
//   - a partial frame in progress is discarded.
//  Accumulate (per transfer):
//   - cnt==0: acc_i <= in_data (load; no multiply).
//   - otherwise: acc_i <= gfmul(acc_i, alpha^(FIRST_ROOT+i)) ^ in_data.
//   - constant multipliers are fixed XOR networks; no runtime exponentiation.
//   - cnt (8 bit) increments per transfer and returns to 0 after the frame-ending transfer.
//  Frame end: a transfer with in_last=1, or the transfer where cnt==N_SYM-1.
//   - len_err pulses (one cycle after the ending transfer) when in_last=1 with cnt!=N_SYM-1,
//     or cnt==N_SYM-1 with in_last=0.
//   - syndromes are still produced and handed over.
//  Two-stage buffer, states of the accumulator side:
//   - ACC:  in_ready=1. On frame end:
//       * hold empty, or hold being acked this cycle: copy the final acc values into hold;
//         out_valid=1 on the next cycle (latency: last symbol at edge t -> out_valid at t+1).
//       * else go to FULL.
//   - FULL: in_ready=0; acc holds the complete frame.
//       * when hold frees (out_ack while out_valid), copy acc -> hold next edge; return to ACC.
//       * no symbol is dropped or overwritten.
//  Hold side:
//   - out_valid clears on the edge where out_ack=1, unless a new frame loads the same edge;
//     in that case out_valid stays 1 with the new data.
//   - out_ack while out_valid=0 is ignored.
//   - syn_nonzero is registered together with the hold load.
//  Back-to-back frames at one symbol per cycle are sustained while downstream acks within
//  N_SYM cycles.
//  Downstream gets a registered, stable snapshot; no combinational path from in_* to syndrome*.
// TESTING
//  - All-zero 255-symbol frame, in_last on symbol 255 -> all syndromes 0x00, syn_nonzero=0,
//    out_valid at t+1, len_err=0.
//  - Zero frame, only the last symbol (r_0) = 0x05 -> every syndrome 0x05, syn_nonzero=1.
//  - Zero frame, only the second-to-last symbol (r_1) = 0x01, FIRST_ROOT=0 -> S_0=0x01,
//    S_1=0x02, S_2=0x04, S_8=0x87.
//  - Hold out_ack=0 and send two frames back-to-back -> in_ready falls after frame 2 ends.
//    Pulse out_ack -> frame-2 syndromes appear next cycle and in_ready rises. Both frames
//    match the reference model.
//  - in_last on symbol 100 -> len_err pulse, cnt restarts at 0, next frame correct.
//    Frame of 255 without in_last -> len_err pulse.
//  - rst_n low at symbol 130 -> out_valid=0 and all outputs 0.
//    Following full frame gives correct syndromes, with no residue from the aborted frame.

Source files
------------

// File: rtl/rsdec_syndrome_calc_if.sv
// Symbol input and syndrome hand-over bus of the RS(255,223) syndrome stage.
interface rsdec_syndrome_calc_if;
  localparam int unsigned NR = 32;
  localparam int unsigned SW = 8;

  logic                  in_valid;
  logic                  in_ready;
  logic [SW-1:0]         in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ack;
  logic [NR-1:0][SW-1:0] syndrome;
  logic                  syn_nonzero;
  logic                  len_err;

  modport master (
    output in_valid, in_data, in_last, out_ack,
    input  in_ready, out_valid, syndrome, syn_nonzero, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ack,
    output in_ready, out_valid, syndrome, syn_nonzero, len_err
  );
endinterface

// File: rtl/rsdec_syndrome_calc.sv
// RS(255,223) syndrome stage: Horner accumulation of 32 syndromes over GF(2^8)/0x187,
// handed to the next stage through an accumulator/hold double buffer.
module rsdec_syndrome_calc #(
  parameter int unsigned N_SYM      = 255,
  parameter int unsigned FIRST_ROOT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  rsdec_syndrome_calc_if.slave bus
);
  localparam int unsigned NR = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_SYM - 1);

  typedef enum logic {ACC, FULL} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic [NR-1:0][SW-1:0] acc;
  logic [NR-1:0][SW-1:0] acc_nxt_c;
  logic [NR-1:0][SW-1:0] hold_src_c;
  logic                  xfer_c, frame_end_c, load_new_c, load_acc_c;

  // Multiply by alpha^k; k is an elaboration constant, so this folds to an XOR network.
  function automatic logic [SW-1:0] mul_alpha_pow(input logic [SW-1:0] a, input int unsigned k);
    logic [SW-1:0] r;
    r = a;
    for (int unsigned j = 0; j < k; j++) begin
      r = {r[SW-2:0], 1'b0} ^ (r[SW-1] ? SW'(8'h87) : SW'(8'h00));
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < NR; gi++) begin : g_horner
    localparam int unsigned EXP = (FIRST_ROOT + gi) % 255;
    assign acc_nxt_c[gi] = (cnt == '0) ? bus.in_data
                                       : (mul_alpha_pow(acc[gi], EXP) ^ bus.in_data);
  end

  assign xfer_c      = bus.in_valid & bus.in_ready;
  assign frame_end_c = xfer_c & (bus.in_last | (cnt == LAST_CNT));
  assign hold_src_c  = load_new_c ? acc_nxt_c : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_next;
  end

  // Accumulator side: finished frame goes straight to hold if it is free, else parks in acc.
  always_comb begin
    state_next = state;
    load_new_c = 1'b0;
    load_acc_c = 1'b0;
    case (state)
      ACC: begin
        if (frame_end_c) begin
          if (!bus.out_valid || bus.out_ack) load_new_c = 1'b1;
          else                               state_next = FULL;
        end
      end
      FULL: begin
        if (bus.out_valid && bus.out_ack) begin
          load_acc_c = 1'b1;
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready    <= 1'b1;
      cnt             <= '0;
      acc             <= '0;
      bus.syndrome    <= '0;
      bus.out_valid   <= 1'b0;
      bus.syn_nonzero <= 1'b0;
      bus.len_err     <= 1'b0;
    end else begin
      bus.in_ready <= (state_next == ACC);
      bus.len_err  <= frame_end_c & (bus.in_last != (cnt == LAST_CNT));
      if (xfer_c) begin
        acc <= acc_nxt_c;
        cnt <= frame_end_c ? '0 : cnt + CW'(1);
      end
      // A load on the ack edge keeps out_valid high with the new frame.
      if (load_new_c || load_acc_c) begin
        bus.syndrome    <= hold_src_c;
        bus.syn_nonzero <= |hold_src_c;
        bus.out_valid   <= 1'b1;
      end else if (bus.out_ack) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rsdec_syndrome_calc.sv
// Bench for rsdec_syndrome_calc: directed vectors, corner sequences and random frames
// against a power-sum syndrome model.
module tb_rsdec_syndrome_calc;
  localparam int unsigned N_SYM = 255;
  localparam int unsigned FR    = 0;
  localparam int unsigned NR    = 32;

  typedef logic [NR-1:0][7:0] syn_t;
  typedef struct {
    int         pos;
    logic [7:0] val;
    logic [7:0] s0, s1, s2, s8;
    logic       nz;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       man_ack = 1'b0;
  logic       drv_ack = 1'b0;
  int         ack_mode = 3;
  int         n_cmp = 0;
  int         n_err = 0;
  int         lerr_seen = 0;
  syn_t       exp_q[$];
  logic [7:0] exp_t [255];
  logic [7:0] frm [256];
  vec_t       tbl [5];

  always #5 clk = ~clk;

  rsdec_syndrome_calc_if bus();

  rsdec_syndrome_calc #(.N_SYM(N_SYM), .FIRST_ROOT(FR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.out_ack = (ack_mode == 3) ? man_ack : drv_ack;

  // Carry-less product reduced modulo x^8+x^7+x^2+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h0187 << (i - 8));
    return p[7:0];
  endfunction

  // S_i = sum_j r_j * alpha^((FR+i)*j), symbol k of a len-symbol frame is r_(len-1-k).
  function automatic syn_t model(input int len);
    syn_t s;
    s = '0;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < len; k++)
        s[i] = s[i] ^ gmul(frm[k], exp_t[((int'(FR) + i) * (len - 1 - k)) % 255]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_syn(input string name, input syn_t req);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_s%0d", name, i), 32'(bus.syndrome[i]), 32'(req[i]));
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 256; k++) frm[k] = 8'($urandom);
  endtask

  task automatic send_frame(input int len, input bit last, input bit gaps);
    exp_q.push_back(model(len));
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frm[k];
      bus.in_last  = last && (k == len - 1);
      for (int w = 0; !bus.in_ready; w++) begin
        if (w > 3000) abort("in_ready_wait");
        @(negedge clk);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    ack_mode = 1;
    for (int w = 0; exp_q.size() != 0 || bus.out_valid; w++) begin
      if (w > 3000) abort("drain");
      @(negedge clk);
    end
    ack_mode = 3;
    repeat (2) @(negedge clk);
  endtask

  // Random downstream acknowledge.
  always @(negedge clk) drv_ack <= (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 3) == 0);

  // Scoreboard: every consumed frame is checked when the ack edge hands it over.
  always @(posedge clk) begin : mon
    syn_t e;
    if (rst_n) begin
      if (bus.len_err) lerr_seen++;
      if (bus.out_valid && bus.out_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(bus.syndrome[0]), 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk_syn("sb", e);
          chk("sb_nonzero", 32'(bus.syn_nonzero), 32'(|e));
        end
      end
    end
  end

  initial begin
    #2000000;
    abort("watchdog");
  end

  initial begin
    syn_t ea, eb;
    int   base, exp_lerr, len;
    bit   last;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    exp_t[0] = 8'h01;
    for (int e = 1; e < 255; e++) exp_t[e] = gmul(exp_t[e-1], 8'h02);

    tbl[0] = '{-1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{254, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 1'b1};
    tbl[2] = '{253, 8'h01, 8'h01, 8'h02, 8'h04, 8'h87, 1'b1};
    tbl[3] = '{253, 8'h02, 8'h02, 8'h04, 8'h08, 8'h89, 1'b1};
    tbl[4] = '{254, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_nonzero", 32'(bus.syn_nonzero), 32'd0);
    chk("rst_len_err", 32'(bus.len_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_syn_or", 32'(|bus.syndrome), 32'd0);

    // Directed single-symbol frames.
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 256; k++) frm[k] = 8'h00;
      if (tbl[t].pos >= 0) frm[tbl[t].pos] = tbl[t].val;
      send_frame(N_SYM, 1'b1, 1'b0);
      chk($sformatf("v%0d_out_valid", t), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_len_err", t), 32'(bus.len_err), 32'd0);
      chk($sformatf("v%0d_s0", t), 32'(bus.syndrome[0]), 32'(tbl[t].s0));
      chk($sformatf("v%0d_s1", t), 32'(bus.syndrome[1]), 32'(tbl[t].s1));
      chk($sformatf("v%0d_s2", t), 32'(bus.syndrome[2]), 32'(tbl[t].s2));
      chk($sformatf("v%0d_s8", t), 32'(bus.syndrome[8]), 32'(tbl[t].s8));
      chk($sformatf("v%0d_nonzero", t), 32'(bus.syn_nonzero), 32'(tbl[t].nz));
      drain();
    end

    // Short frame and missing in_last.
    rand_frame();
    send_frame(100, 1'b1, 1'b0);
    chk("short_len_err", 32'(bus.len_err), 32'd1);
    chk("short_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("short_len_err_pulse", 32'(bus.len_err), 32'd0);
    drain();
    rand_frame();
    send_frame(N_SYM, 1'b1, 1'b1);
    drain();
    rand_frame();
    send_frame(N_SYM, 1'b0, 1'b0);
    chk("nolast_len_err", 32'(bus.len_err), 32'd1);
    drain();

    // Back-to-back with downstream stalled.
    man_ack = 1'b0;
    rand_frame();
    ea = model(N_SYM);
    send_frame(N_SYM, 1'b1, 1'b0);
    rand_frame();
    eb = model(N_SYM);
    send_frame(N_SYM, 1'b1, 1'b0);
    chk("b2b_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    chk_syn("b2b_hold_a", ea);
    repeat (5) @(negedge clk);
    chk("b2b_stall_in_ready", 32'(bus.in_ready), 32'd0);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("b2b_in_ready_high", 32'(bus.in_ready), 32'd1);
    chk("b2b_out_valid_kept", 32'(bus.out_valid), 32'd1);
    chk_syn("b2b_hold_b", eb);
    drain();

    // Reset in the middle of a frame while a frame is held.
    rand_frame();
    send_frame(N_SYM, 1'b1, 1'b0);
    rand_frame();
    for (int k = 0; k < 130; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = frm[k];
      @(negedge clk);
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_nonzero", 32'(bus.syn_nonzero), 32'd0);
    chk("mrst_len_err", 32'(bus.len_err), 32'd0);
    chk("mrst_syn_or", 32'(|bus.syndrome), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    rand_frame();
    send_frame(N_SYM, 1'b1, 1'b0);
    drain();

    // Random frames, random gaps and random acknowledge.
    base = lerr_seen;
    exp_lerr = 0;
    ack_mode = 2;
    for (int f = 0; f < 10; f++) begin
      rand_frame();
      case ($urandom_range(0, 5))
        0:       begin len = $urandom_range(1, N_SYM - 1); last = 1'b1; exp_lerr++; end
        1:       begin len = N_SYM; last = 1'b0; exp_lerr++; end
        default: begin len = N_SYM; last = 1'b1; end
      endcase
      send_frame(len, last, f[0]);
    end
    drain();
    chk("rand_len_err_count", 32'(lerr_seen - base), 32'(exp_lerr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
